// File: rtl/debug_pkg.sv
// Framing types and constants shared by the debug link transmitter, receiver and host script.
// Holds no logic, so it adds no latency and has no flow control.
package debug_pkg;

    localparam int         RESP_FRAME_BYTES = 6;
    localparam logic [7:0] DBG_HDR_BYTE     = 8'hA5;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/resp_fifo.sv
// Circular response FIFO. A pushed word is visible at the head one edge later.
// Pushes are dropped while not_full (registered) is low; a pop with a push keeps count unchanged.
module resp_fifo
    import debug_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  resp_t                  wr_word,
    input  logic                   pop,
    output resp_t                  rd_word,
    output logic [$clog2(DEPTH):0] count,
    output logic                   not_full
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    resp_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_next;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && not_full;
    assign do_pop  = pop && (count != '0);
    assign rd_word = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            not_full <= (count_next != FULL);
        end
    end

endmodule

// File: rtl/debug_resp_tx.sv
// Serialises buffered {tag, data} responses as 6-byte 8N1 frames; line goes low two edges after a push into an idle block.
// in_ready drops while the FIFO is full; frames run back-to-back with one idle-high cycle between them.
module debug_resp_tx
    import debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] HDR_BYTE     = DBG_HDR_BYTE
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_tag,
    input  logic [31:0]                 in_data,
    output logic                        tx_serial,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 frames_sent
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(RESP_FRAME_BYTES - 1);

    tx_state_t                      state;
    tx_state_t                      state_next;
    logic [BW-1:0]                  baud_cnt;
    logic [2:0]                     bit_idx;
    logic [2:0]                     byte_idx;
    logic [8*RESP_FRAME_BYTES-1:0]  frame_sr;
    logic [15:0]                    sent_cnt;
    resp_t                          in_word;
    resp_t                          head;
    logic                           has_data;
    logic                           baud_last;
    logic                           pop;
    logic                           line;
    logic                           frame_done;

    assign in_word     = '{tag: in_tag, data: in_data};
    assign has_data    = (fifo_count != '0);
    assign baud_last   = (baud_cnt == BAUD_LAST);
    assign frames_sent = sent_cnt;

    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (in_valid),
        .wr_word  (in_word),
        .pop      (pop),
        .rd_word  (head),
        .count    (fifo_count),
        .not_full (in_ready)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (has_data) state_next = START;
            START: if (baud_last) state_next = DATA;
            DATA:  if (baud_last && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (baud_last) state_next = (byte_idx == LAST_BYTE) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        line       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE:  pop = has_data;
            START: line = 1'b0;
            DATA:  line = frame_sr[bit_idx];
            STOP:  frame_done = baud_last && (byte_idx == LAST_BYTE);
            default: ;
        endcase
    end

    // The line is driven from a register, so it trails the state by one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            frame_sr  <= '0;
            busy      <= 1'b0;
            tx_serial <= 1'b1;
        end else begin
            tx_serial <= line;
            if (pop) begin
                frame_sr <= {head.data, head.tag, HDR_BYTE};
                baud_cnt <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
                busy     <= 1'b1;
            end else if (state != IDLE) begin
                if (!baud_last) begin
                    baud_cnt <= baud_cnt + BW'(1);
                end else begin
                    baud_cnt <= '0;
                    case (state)
                        DATA: bit_idx <= bit_idx + 3'd1;
                        STOP: begin
                            if (frame_done) begin
                                busy <= 1'b0;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                frame_sr <= frame_sr >> 8;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sent_cnt <= '0;
        end else begin
            sent_cnt <= sent_cnt + 16'(frame_done);
        end
    end

endmodule

// File: tb/tb_debug_resp_tx.sv
// Directed bench for debug_resp_tx with a line monitor that decodes 8N1 frames.
module tb_debug_resp_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_tag;
    logic [31:0] in_data;
    logic        tx_serial;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] frames_sent;

    int tests_run = 0;
    int failed    = 0;

    debug_resp_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .in_data     (in_data),
        .tx_serial   (tx_serial),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .frames_sent (frames_sent)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Line monitor: samples every negedge, 10 bits of CPB samples per byte, 6 bytes per frame.
    logic [47:0] frame_q [$];
    int          gap_q [$];
    int          mon_glitch  = 0;
    int          mon_framing = 0;
    int          busy_cycles = 0;
    int          idle_run    = 0;
    bit          in_frame    = 0;
    bit          have_prev   = 0;
    int          k           = 0;
    logic        v;
    logic [9:0]  byt;
    logic [47:0] sh;

    initial begin
        forever begin
            @(negedge CLK);
            if (busy === 1'b1) busy_cycles++;
            if (RST === 1'b1) begin
                in_frame  = 0;
                have_prev = 0;
                idle_run  = 0;
            end else begin
                if (!in_frame) begin
                    if (tx_serial === 1'b0) begin
                        if (have_prev) gap_q.push_back(idle_run);
                        in_frame = 1;
                        k        = 0;
                    end else begin
                        idle_run++;
                    end
                end
                if (in_frame) begin
                    if (k % CPB == 0) begin
                        v                       = tx_serial;
                        byt[(k / CPB) % 10]     = tx_serial;
                    end else if (tx_serial !== v) begin
                        mon_glitch++;
                    end
                    if (k % CPB == CPB - 1 && (k / CPB) % 10 == 9) begin
                        if (byt[0] !== 1'b0 || byt[9] !== 1'b1) mon_framing++;
                        sh[8 * ((k / CPB) / 10) +: 8] = byt[8:1];
                    end
                    k++;
                    if (k == 60 * CPB) begin
                        frame_q.push_back(sh);
                        in_frame  = 0;
                        have_prev = 1;
                        idle_run  = 0;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        frame_q.delete();
        gap_q.delete();
        have_prev   = 0;
        mon_glitch  = 0;
        mon_framing = 0;
        busy_cycles = 0;
    endtask

    task automatic push_word(input logic [7:0] tag, input logic [31:0] data);
        in_valid = 1'b1;
        in_tag   = tag;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int cyc = 0;
        while (frame_q.size() < n && cyc < limit) begin
            step();
            cyc++;
        end
        tests_run++;
        if (frame_q.size() < n) begin
            failed++;
            $display("FAIL wait_frames: got %0d frames, required %0d", frame_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int limit);
        int cyc = 0;
        while ((busy !== 1'b0 || fifo_count !== 3'd0) && cyc < limit) begin
            step();
            cyc++;
        end
        repeat (4) step();
        tests_run++;
        if (busy !== 1'b0 || fifo_count !== 3'd0) begin
            failed++;
            $display("FAIL wait_idle: busy=%b count=%0d, required idle", busy, fifo_count);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        tests_run++;
        if ({tx_serial, busy, in_ready} !== 3'b101) begin
            failed++;
            $display("FAIL reset_flags: tx/busy/rdy=%b required 101", {tx_serial, busy, in_ready});
        end
        tests_run++;
        if (fifo_count !== 3'd0 || frames_sent !== 16'd0) begin
            failed++;
            $display("FAIL reset_counts: count=%0d sent=%0d required 0/0", fifo_count, frames_sent);
        end
        RST = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single_frame();
        clear_mon();
        push_word(8'h01, 32'hDEADBEEF);
        tests_run++;
        if (fifo_count !== 3'd1) begin
            failed++;
            $display("FAIL single_count_n1: got %0d required 1", fifo_count);
        end
        step();
        tests_run++;
        if ({tx_serial, busy, fifo_count} !== {1'b1, 1'b1, 3'd0}) begin
            failed++;
            $display("FAIL single_pop: tx/busy/count=%b required 1_1_000", {tx_serial, busy, fifo_count});
        end
        step();
        tests_run++;
        if (tx_serial !== 1'b0) begin
            failed++;
            $display("FAIL single_start_n2: tx=%b required 0", tx_serial);
        end
        wait_frames(1, 400);
        tests_run++;
        if (frame_q.size() != 1 || frame_q[0] !== 48'hDEADBEEF_01_A5) begin
            failed++;
            $display("FAIL single_bytes: got %h required deadbeef01a5", frame_q.size() > 0 ? frame_q[0] : 48'h0);
        end
        tests_run++;
        if (mon_glitch != 0 || mon_framing != 0) begin
            failed++;
            $display("FAIL single_bit_timing: glitch=%0d framing=%0d required 0/0", mon_glitch, mon_framing);
        end
        tests_run++;
        if (busy_cycles != 240 || frames_sent !== 16'd1) begin
            failed++;
            $display("FAIL single_busy_sent: busy=%0d sent=%0d required 240/1", busy_cycles, frames_sent);
        end
    endtask

    task automatic test_fifo_fill();
        int acc = 0;
        int cyc = 0;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_tag   = 8'(i);
            in_data  = 32'(i);
            if (in_ready === 1'b1) acc++;
            step();
        end
        in_valid = 1'b0;
        tests_run++;
        if (acc != 5 || fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL fill_accept: acc=%0d count=%0d rdy=%b required 5/4/0", acc, fifo_count, in_ready);
        end
        while (busy === 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL fill_frame0_end: busy=%b rdy=%b required 0/0", busy, in_ready);
        end
        step();
        tests_run++;
        if (in_ready !== 1'b1 || fifo_count !== 3'd3 || busy !== 1'b1) begin
            failed++;
            $display("FAIL fill_ready_rise: rdy=%b count=%0d busy=%b required 1/3/1", in_ready, fifo_count, busy);
        end
        wait_frames(5, 1500);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (frame_q.size() <= i || frame_q[i] !== {32'(i), 8'(i), 8'hA5}) begin
                failed++;
                $display("FAIL fill_frame%0d: got %h required %h", i,
                         frame_q.size() > i ? frame_q[i] : 48'h0, {32'(i), 8'(i), 8'hA5});
            end
        end
        tests_run++;
        if (gap_q.size() != 4 || gap_q[0] != 1 || gap_q[1] != 1 || gap_q[2] != 1 || gap_q[3] != 1) begin
            failed++;
            $display("FAIL fill_gaps: n=%0d first=%0d required 4 gaps of 1", gap_q.size(),
                     gap_q.size() > 0 ? gap_q[0] : -1);
        end
        tests_run++;
        if (mon_glitch != 0 || mon_framing != 0 || frames_sent !== 16'd6) begin
            failed++;
            $display("FAIL fill_line: glitch=%0d framing=%0d sent=%0d required 0/0/6",
                     mon_glitch, mon_framing, frames_sent);
        end
    endtask

    task automatic test_push_pop();
        clear_mon();
        push_word(8'h11, 32'h12345678);
        push_word(8'h22, 32'h9ABCDEF0);
        tests_run++;
        if (fifo_count !== 3'd1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL pushpop_count: count=%0d busy=%b required 1/1", fifo_count, busy);
        end
        wait_frames(2, 800);
        tests_run++;
        if (frame_q.size() != 2 || frame_q[0] !== 48'h12345678_11_A5 || frame_q[1] !== 48'h9ABCDEF0_22_A5) begin
            failed++;
            $display("FAIL pushpop_order: n=%0d f0=%h f1=%h required 2 frames", frame_q.size(),
                     frame_q.size() > 0 ? frame_q[0] : 48'h0, frame_q.size() > 1 ? frame_q[1] : 48'h0);
        end
        repeat (4) step();
        tests_run++;
        if (frames_sent !== 16'd8 || fifo_count !== 3'd0) begin
            failed++;
            $display("FAIL pushpop_sent: sent=%0d count=%0d required 8/0", frames_sent, fifo_count);
        end
    endtask

    task automatic test_bit_pattern();
        clear_mon();
        push_word(8'hFF, 32'h00000000);
        wait_frames(1, 400);
        tests_run++;
        if (frame_q.size() != 1 || frame_q[0] !== 48'h00000000_FF_A5) begin
            failed++;
            $display("FAIL pattern_bytes: got %h required 00000000ffa5", frame_q.size() > 0 ? frame_q[0] : 48'h0);
        end
        tests_run++;
        if (mon_glitch != 0 || mon_framing != 0) begin
            failed++;
            $display("FAIL pattern_line: glitch=%0d framing=%0d required 0/0", mon_glitch, mon_framing);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        push_word(8'h5A, 32'hCAFEF00D);
        push_word(8'h6B, 32'h01020304);
        repeat (90) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        tests_run++;
        if ({tx_serial, busy} !== 2'b10 || fifo_count !== 3'd0 || frames_sent !== 16'd0) begin
            failed++;
            $display("FAIL midreset_state: tx/busy=%b count=%0d sent=%0d required 10/0/0",
                     {tx_serial, busy}, fifo_count, frames_sent);
        end
        repeat (300) step();
        tests_run++;
        if (frames_sent !== 16'd0 || frame_q.size() != 0 || tx_serial !== 1'b1) begin
            failed++;
            $display("FAIL midreset_no_partial: sent=%0d frames=%0d tx=%b required 0/0/1",
                     frames_sent, frame_q.size(), tx_serial);
        end
        clear_mon();
        push_word(8'h77, 32'h89ABCDEF);
        wait_frames(1, 400);
        repeat (4) step();
        tests_run++;
        if (frame_q.size() != 1 || frame_q[0] !== 48'h89ABCDEF_77_A5 || frames_sent !== 16'd1
            || mon_glitch != 0 || mon_framing != 0) begin
            failed++;
            $display("FAIL midreset_recover: got %h sent=%0d required 89abcdef77a5/1",
                     frame_q.size() > 0 ? frame_q[0] : 48'h0, frames_sent);
        end
    endtask

    task automatic test_counter_wrap();
        clear_mon();
        force dut.sent_cnt = 16'hFFFF;
        step();
        release dut.sent_cnt;
        step();
        tests_run++;
        if (frames_sent !== 16'hFFFF) begin
            failed++;
            $display("FAIL wrap_preload: got %h required ffff", frames_sent);
        end
        push_word(8'h3C, 32'h0000FFFF);
        wait_frames(1, 400);
        repeat (4) step();
        tests_run++;
        if (frames_sent !== 16'h0000 || frame_q.size() != 1 || frame_q[0] !== 48'h0000FFFF_3C_A5) begin
            failed++;
            $display("FAIL wrap_zero: sent=%h frame=%h required 0000/0000ffff3ca5", frames_sent,
                     frame_q.size() > 0 ? frame_q[0] : 48'h0);
        end
    endtask

    initial begin
        RST      = 1'b0;
        in_valid = 1'b0;
        in_tag   = 8'h00;
        in_data  = 32'h0;
        step();
        test_reset();
        test_single_frame();
        wait_idle(400);
        test_fifo_fill();
        wait_idle(400);
        test_push_pop();
        wait_idle(400);
        test_bit_pattern();
        wait_idle(400);
        test_reset_mid_frame();
        wait_idle(400);
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/debug_resp_tx.md
Name: debug_resp_tx

Overview:
UART transmit-side response path for the debug link. The debug controller receives host commands on rx; this block returns results on tx.
- Accepts {tag, 32-bit data} response words over a valid/ready handshake.
- Buffers them in a small FIFO.
- Serialises each word as a fixed 6-byte 8N1 frame to the host.
- Runs on the board clock, beside the debug controller, outside the CPU reset domain.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range is >= 2.
FIFO_DEPTH, 4, response FIFO entries; must be a power of two and >= 2.
HDR_BYTE, 8'hA5, sync byte that opens every frame.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
in_valid  input  1  response word offered
in_ready  output  1  FIFO can accept this cycle
in_tag  input  8  response tag (command echo / status)
in_data  input  32  response payload
tx_serial  output  1  UART line, idle high
busy  output  1  frame in progress
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held
frames_sent  output  16  completed-frame counter

Behaviour:
- Reset (RST sampled high at a rising edge) forces the following on that edge:
  - tx_serial=1, busy=0, fifo_count=0, frames_sent=0, in_ready=1.
  - FSM to IDLE.
- Reset mid-frame truncates the current byte immediately; the line returns high; no partial frame completes.
- Handshake:
  - A push happens when in_valid && in_ready at a rising edge.
  - in_ready is registered and equals (fifo_count != FIFO_DEPTH).
  - Data and tag must be stable only in the push cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - A push and a pop in the same cycle are legal when not full; count is unchanged.
  - When full, no push can occur (in_ready=0); a pop alone frees one slot, and in_ready rises on the next edge.
- Frame format, bytes in order:
  1. HDR_BYTE
  2. tag
  3. data[7:0]
  4. data[15:8]
  5. data[23:16]
  6. data[31:24]
- Byte format: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Each bit holds for exactly CLKS_PER_BIT cycles. A frame is 60 bit-times.
- There is no idle gap between bytes of a frame: the next start bit immediately follows the previous stop bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count != 0, pop the head into the frame shift register, byte_idx=0, busy=1, go to START.
  - START: drive 0; after CLKS_PER_BIT cycles, go to DATA with bit_idx=0.
  - DATA: drive current bit; after each CLKS_PER_BIT cycles, bit_idx++; after bit 7, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then:
    - if byte_idx < 5: byte_idx++, go to START;
    - else: frames_sent++ (wraps 16'hFFFF to 0), busy=0, go to IDLE.
- Latency:
  - Push at edge N into an empty FIFO with the FSM in IDLE.
  - FIFO entry visible at N+1; IDLE pops it at edge N+1.
  - tx_serial registered low from edge N+2.
- Back-to-back frames: the stop bit of byte 6 completes; IDLE is entered for exactly one cycle (line high); the next start bit begins on the following edge.
- Counters: baud counter counts 0..CLKS_PER_BIT-1; bit counter 0..7; byte counter 0..5. All are registered and cleared by RST.

Decomposition:
- Shared package debug_pkg:
  - typedef resp_t {tag[7:0], data[31:0]};
  - enum tx_state_t {IDLE, START, DATA, STOP};
  - constants RESP_FRAME_BYTES=6 and DBG_HDR_BYTE=8'hA5, so the receiver and the host script share framing.
- One sub-module: resp_fifo (parameterised sync FIFO with count, registered not_full).
- The bit/byte serialiser FSM stays in debug_resp_tx.

Test Plan:
- Single frame (CLKS_PER_BIT=4): push tag 0x01, data 0xDEADBEEF at edge N.
  - tx_serial falls at N+2.
  - Decoded bytes A5 01 EF BE AD DE.
  - Each bit is exactly 4 cycles.
  - busy high for 240 cycles; frames_sent=1.
- FIFO fill: hold in_valid for 6 consecutive cycles with data 0..5.
  - Exactly 5 accepted (words 0-4), fifo_count=4, in_ready low.
  - After frame 0 completes, in_ready rises one cycle later.
  - All 5 frames are emitted in order with 1 idle-high cycle between frames.
- Simultaneous push/pop: push at the exact edge IDLE pops a 1-entry FIFO.
  - fifo_count stays 1; no data lost or duplicated.
- Reset mid-frame: assert RST for 1 cycle during the DATA state of byte 3.
  - Next edge: tx_serial=1, busy=0, fifo_count=0, frames_sent=0.
  - A subsequent push produces a clean complete frame.
- Counter wrap: preload or run frames_sent to 16'hFFFF, send one frame.
  - frames_sent=0.
- Bit-pattern check: data 0x00000000 and tag 0xFF.
  - Start and stop bits are distinguishable.
  - No glitch on the line at byte boundaries.
